// File: rtl/axis_bram_adapter_v1_0_m00_axis_if.sv
// AXI4-Stream bundle driven by the BRAM-to-stream adapter.
// The master modport is the adapter's side; the slave modport is the downstream consumer's side.
interface axis_bram_adapter_v1_0_m00_axis_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    TVALID;
    logic [DATA_WIDTH-1:0]   TDATA;
    logic [DATA_WIDTH/8-1:0] TSTRB;
    logic                    TLAST;
    logic                    TREADY;

    modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/axis_bram_adapter_v1_0_m00_axis.sv
// Streams LEN consecutive BRAM words, starting at BASE_ADDR, out as one AXI4-Stream block.
// Reads are issued through a 2-entry {data,last} skid FIFO, so back-pressure never loses a BRAM word.
module axis_bram_adapter_v1_0_m00_axis #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH         = 10
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              START,
    input  logic [C_ADDR_WIDTH-1:0]           BASE_ADDR,
    input  logic [C_ADDR_WIDTH:0]             LEN,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              BRAM_EN,
    output logic [C_ADDR_WIDTH-1:0]           BRAM_ADDR,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   BRAM_DOUT,
    axis_bram_adapter_v1_0_m00_axis_if.master M_AXIS
);

    localparam logic [C_ADDR_WIDTH-1:0] ADDR_ONE = C_ADDR_WIDTH'(1);
    localparam logic [C_ADDR_WIDTH:0]   CNT_ONE  = (C_ADDR_WIDTH + 1)'(1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                          r_state;
    state_t                          w_nextState;
    logic [C_ADDR_WIDTH-1:0]         r_rdPtr;
    logic [C_ADDR_WIDTH:0]           r_readsLeft;
    logic [C_ADDR_WIDTH:0]           r_beatsLeft;
    logic                            r_inFlight;
    logic                            r_inFlightLast;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] r_fifoData [2];
    logic                            r_fifoLast [2];
    logic                            r_head;
    logic                            r_tail;
    logic [1:0]                      r_count;
    logic                            r_done;

    logic                            w_start;
    logic                            w_valid;
    logic                            w_pop;
    logic                            w_lastPop;
    logic [2:0]                      w_occAfterPop;

    assign w_start   = START && (r_state == S_IDLE) && (LEN != '0);
    assign w_valid   = (r_count != 2'd0);
    assign w_pop     = w_valid && M_AXIS.TREADY;
    assign w_lastPop = w_pop && (r_beatsLeft == CNT_ONE);

    // Occupancy is taken net of this cycle's pop, so a full-rate stream keeps one read per beat in flight.
    assign w_occAfterPop = {1'b0, r_count} + {2'b00, r_inFlight} - {2'b00, w_pop};

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_start)   w_nextState = S_STREAM;
            S_STREAM: if (w_lastPop) w_nextState = S_IDLE;
            default:                 w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY          = (r_state == S_STREAM);
        BRAM_EN       = (r_state == S_STREAM) && (r_readsLeft != '0) && (w_occAfterPop < 3'd2);
        BRAM_ADDR     = r_rdPtr;
        DONE          = r_done;
        M_AXIS.TVALID = w_valid;
        M_AXIS.TDATA  = r_fifoData[r_head];
        M_AXIS.TLAST  = r_fifoLast[r_head];
        M_AXIS.TSTRB  = '1;
    end

    // Read pointer/counters, the one-cycle BRAM read pipeline and the skid FIFO.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_rdPtr        <= '0;
            r_readsLeft    <= '0;
            r_beatsLeft    <= '0;
            r_inFlight     <= 1'b0;
            r_inFlightLast <= 1'b0;
            r_fifoData[0]  <= '0;
            r_fifoData[1]  <= '0;
            r_fifoLast[0]  <= 1'b0;
            r_fifoLast[1]  <= 1'b0;
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
            r_count        <= 2'd0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_lastPop;

            if (w_start) begin
                r_rdPtr     <= BASE_ADDR;
                r_readsLeft <= LEN;
            end else if (BRAM_EN) begin
                r_rdPtr     <= r_rdPtr + ADDR_ONE;
                r_readsLeft <= r_readsLeft - CNT_ONE;
            end

            if (w_start) begin
                r_beatsLeft <= LEN;
            end else if (w_pop) begin
                r_beatsLeft <= r_beatsLeft - CNT_ONE;
            end

            r_inFlight     <= BRAM_EN;
            r_inFlightLast <= BRAM_EN && (r_readsLeft == CNT_ONE);

            if (r_inFlight) begin
                r_fifoData[r_tail] <= BRAM_DOUT;
                r_fifoLast[r_tail] <= r_inFlightLast;
                r_tail             <= ~r_tail;
            end

            if (w_pop) begin
                r_head <= ~r_head;
            end

            case ({r_inFlight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/axis_bram_adapter_v1_0_m00_axis.md
AXIS_BRAM_ADAPTER_V1_0_M00_AXIS -- requirements
Module: axis_bram_adapter_v1_0_M00_AXIS

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 32, stream and BRAM data width in bits.
REQ-002 Parameter C_ADDR_WIDTH, default 10, BRAM word-address width.
REQ-003 M_AXIS_ACLK  in  1  single clock; all state changes on its rising edge.
REQ-004 M_AXIS_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 START  in  1  one-cycle request to stream a block.
REQ-006 BASE_ADDR  in  C_ADDR_WIDTH  first BRAM word address, sampled with START.
REQ-007 LEN  in  C_ADDR_WIDTH+1  number of words to send, sampled with START.
REQ-008 BUSY  out  1  high from accepted START until the last beat handshakes.
REQ-009 DONE  out  1  one-cycle pulse on the last-beat handshake.
REQ-010 BRAM_EN  out  1  BRAM read enable; read latency is exactly 1 cycle.
REQ-011 BRAM_ADDR  out  C_ADDR_WIDTH  BRAM read word address.
REQ-012 BRAM_DOUT  in  C_M_AXIS_TDATA_WIDTH  BRAM read data, valid one cycle after BRAM_EN.
REQ-013 M_AXIS_TVALID  out  1  stream beat valid.
REQ-014 M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
REQ-015 M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes.
REQ-016 M_AXIS_TLAST  out  1  marks final beat of the block.
REQ-017 M_AXIS_TREADY  in  1  downstream accept.

Function
REQ-018 States: IDLE, STREAM; IDLE->STREAM on START=1 with LEN!=0; STREAM->IDLE on the handshake (TVALID&TREADY) of the beat carrying TLAST.
REQ-019 START while BUSY=1, or START with LEN=0, SHALL be ignored (no BUSY, no DONE, no reads).
REQ-020 On accepted START the block SHALL latch BASE_ADDR as read pointer and LEN as remaining-reads and remaining-beats counters.
REQ-021 Output buffering: 2-entry FIFO of {data,last}; BRAM_EN SHALL assert only when remaining-reads>0 and (FIFO occupancy + reads in flight) < 2.
REQ-022 Each BRAM_EN cycle SHALL increment the read pointer by 1 modulo 2^C_ADDR_WIDTH (wrap from all-ones to 0) and decrement remaining-reads.
REQ-023 BRAM_DOUT SHALL be written into the FIFO on the cycle after BRAM_EN; its last flag set when it is the LEN-th word read.
REQ-024 M_AXIS_TVALID SHALL equal FIFO non-empty; TDATA/TLAST SHALL present the FIFO head; TSTRB SHALL be all ones.
REQ-025 Once TVALID is high, TDATA/TLAST SHALL stay stable until handshake; TVALID SHALL not drop without handshake.
REQ-026 Simultaneous FIFO write and head pop SHALL keep occupancy unchanged and lose no word.
REQ-027 Latency: START sampled at edge N -> BRAM_EN high during cycle N..N+1, first TVALID high after edge N+2.
REQ-028 With TREADY held high the block SHALL sustain one beat per cycle; LEN beats take LEN+1 cycles after first BRAM_EN.
REQ-029 TREADY low SHALL stall reads so the FIFO never overflows and BRAM_DOUT is never dropped.
REQ-030 DONE SHALL pulse high exactly in the cycle after the TLAST handshake edge, simultaneously with BUSY falling; a new START is accepted from that cycle.
REQ-031 Exactly LEN beats SHALL be emitted per accepted START, TLAST on beat LEN only.

Reset
REQ-032 ARESETN=0 SHALL immediately force IDLE, BUSY=0, DONE=0, BRAM_EN=0, BRAM_ADDR=0, TVALID=0, TLAST=0, TDATA=0, FIFO empty, counters 0.
REQ-033 Reset mid-block SHALL abandon the block; after release no beat or DONE of the aborted block appears; the next START is processed normally.
REQ-034 Outputs SHALL leave reset values only on the first rising edge after ARESETN deasserts.

Verification
REQ-035 BRAM preloaded mem[a]=a; BASE_ADDR=0, LEN=4, TREADY=1 -> beats 0,1,2,3, TLAST on 3, TVALID first 2 cycles after START, DONE one pulse.
REQ-036 BASE_ADDR=1022, LEN=4, C_ADDR_WIDTH=10 -> BRAM_ADDR 1022,1023,0,1; data 1022,1023,0,1.
REQ-037 LEN=6, TREADY toggled 1,0,0,1,0,1,... -> beats 0..5 in order, no drops/duplicates, TDATA stable while stalled, BRAM_EN never makes occupancy exceed 2.
REQ-038 START with LEN=0, and START during BUSY -> no BRAM_EN, no extra beats, no DONE.
REQ-039 LEN=1 -> single beat with TLAST=1, DONE one cycle after it; back-to-back START in DONE cycle accepted.
REQ-040 ARESETN pulsed low after beat 2 of LEN=8 -> TVALID/BUSY drop at once; subsequent LEN=2 block streams 2 correct beats.
